// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS program-loading path.
//   WORD_W         : instruction word width
//   BYTE_W         : width of one program byte on the load stream
//   loader_state_t : imem_loader FSM states
package mips_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    WRITE,
    DONE
  } loader_state_t;

endpackage

// File: rtl/imem_loader.sv
// Program loader for the MIPS instruction memory.
// Takes a byte stream over valid/ready, packs it big-endian into 32-bit
// words and writes each word to consecutive word addresses. The core is
// held in reset (cpu_rst=1) until the load completes.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   start                 begin a load (honoured in IDLE and DONE only)
//   byte_valid/byte_data  program byte stream
//   byte_last             marks the final byte (qualified by byte_valid)
//   byte_ready            loader accepts a byte this cycle
//   mem_we/addr/wdata     instruction-memory write port, one strobe per word
//   cpu_rst               reset to the MIPS core
//   done                  load complete
//   overflow              memory filled before byte_last arrived
//   word_count            words written during this load
// All outputs are registered.
module imem_loader
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_data,
  input  logic              byte_last,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  loader_state_t     state_q, state_d;
  logic [1:0]        lane_q, lane_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic              last_q, last_d;

  logic              byte_ready_d;
  logic              mem_we_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [WORD_W-1:0] mem_wdata_d;
  logic              cpu_rst_d;
  logic              done_d;
  logic              overflow_d;
  logic [ADDR_W:0]   word_count_d;

  logic              accept;
  logic [WORD_W-1:0] merged;

  // byte_ready is only ever high in RECV, so accept implies RECV.
  assign accept = byte_valid && byte_ready;

  // Current shift register with the incoming byte dropped into its lane;
  // unfilled low lanes stay zero because shreg is cleared per word.
  always_comb begin
    merged = shreg_q;
    case (lane_q)
      2'd0:    merged[31:24] = byte_data;
      2'd1:    merged[23:16] = byte_data;
      2'd2:    merged[15:8]  = byte_data;
      default: merged[7:0]   = byte_data;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    lane_d       = lane_q;
    shreg_d      = shreg_q;
    last_d       = last_q;
    byte_ready_d = byte_ready;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr;
    mem_wdata_d  = mem_wdata;
    cpu_rst_d    = cpu_rst;
    done_d       = done;
    overflow_d   = overflow;
    word_count_d = word_count;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d      = RECV;
          lane_d       = '0;
          shreg_d      = '0;
          last_d       = 1'b0;
          mem_addr_d   = '0;
          word_count_d = '0;
          overflow_d   = 1'b0;
          byte_ready_d = 1'b1;
          cpu_rst_d    = 1'b1;
          done_d       = 1'b0;
        end
      end

      RECV: begin
        if (accept) begin
          shreg_d = merged;
          lane_d  = lane_q + 2'd1;
          if (lane_q == 2'd3 || byte_last) begin
            state_d      = WRITE;
            byte_ready_d = 1'b0;
            mem_we_d     = 1'b1;
            mem_wdata_d  = merged;
            last_d       = byte_last;
          end
        end
      end

      WRITE: begin
        word_count_d = word_count + 1'b1;
        lane_d       = '0;
        shreg_d      = '0;
        // Address saturates at the top slot; the overflow path ends the load.
        if (mem_addr != ADDR_MAX) begin
          mem_addr_d = mem_addr + 1'b1;
        end
        if (last_q) begin
          state_d   = DONE;
          done_d    = 1'b1;
          cpu_rst_d = 1'b0;
        end else if (mem_addr == ADDR_MAX) begin
          state_d    = DONE;
          done_d     = 1'b1;
          cpu_rst_d  = 1'b0;
          overflow_d = 1'b1;
        end else begin
          state_d      = RECV;
          byte_ready_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      lane_q     <= '0;
      shreg_q    <= '0;
      last_q     <= 1'b0;
      byte_ready <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_rst    <= 1'b1;
      done       <= 1'b0;
      overflow   <= 1'b0;
      word_count <= '0;
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      shreg_q    <= shreg_d;
      last_q     <= last_d;
      byte_ready <= byte_ready_d;
      mem_we     <= mem_we_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      cpu_rst    <= cpu_rst_d;
      done       <= done_d;
      overflow   <= overflow_d;
      word_count <= word_count_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start1 = 1'b0;
  logic start2 = 1'b0;
  logic byte_valid = 1'b0;
  logic [7:0] byte_data = '0;
  logic byte_last = 1'b0;
  logic sel = 1'b0;

  logic        br1, we1, cpu1, done1, ovf1;
  logic [7:0]  addr1;
  logic [31:0] wdata1;
  logic [8:0]  wc1;

  logic        br2, we2, cpu2, done2, ovf2;
  logic [1:0]  addr2;
  logic [31:0] wdata2;
  logic [2:0]  wc2;

  int checks = 0;
  int failures = 0;

  logic [31:0] wa1[$];
  logic [31:0] wd1[$];
  logic [31:0] wa2[$];
  logic [31:0] wd2[$];

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(8)) dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_last(byte_last),
    .byte_ready(br1), .mem_we(we1), .mem_addr(addr1), .mem_wdata(wdata1),
    .cpu_rst(cpu1), .done(done1), .overflow(ovf1), .word_count(wc1)
  );

  imem_loader #(.ADDR_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_last(byte_last),
    .byte_ready(br2), .mem_we(we2), .mem_addr(addr2), .mem_wdata(wdata2),
    .cpu_rst(cpu2), .done(done2), .overflow(ovf2), .word_count(wc2)
  );

  // Write monitors (observed side only).
  always @(negedge clk) begin
    if (we1 === 1'b1) begin
      wa1.push_back({24'd0, addr1});
      wd1.push_back(wdata1);
    end
    if (we2 === 1'b1) begin
      wa2.push_back({30'd0, addr2});
      wd2.push_back(wdata2);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one byte and hold it until accepted (bounded wait).
  task automatic send(input logic [7:0] b, input logic l);
    int n;
    logic rdy;
    n = 0;
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    byte_last  = l;
    rdy = sel ? br2 : br1;
    while (rdy !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
      rdy = sel ? br2 : br1;
    end
    if (n >= 50) begin
      chk("send_timeout", 32'd1, 32'd0);
    end else begin
      @(posedge clk);
    end
    #1;
    byte_valid = 1'b0;
    byte_last  = 1'b0;
  endtask

  task automatic pulse_start1();
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
  endtask

  initial begin
    // Asynchronous reset with no clock edge in between.
    #2 rst = 1'b1;
    #1;
    chk("rst_cpu_rst",    {31'd0, cpu1},  32'd1);
    chk("rst_byte_ready", {31'd0, br1},   32'd0);
    chk("rst_mem_we",     {31'd0, we1},   32'd0);
    chk("rst_mem_addr",   {24'd0, addr1}, 32'd0);
    chk("rst_mem_wdata",  wdata1,         32'd0);
    chk("rst_done",       {31'd0, done1}, 32'd0);
    chk("rst_overflow",   {31'd0, ovf1},  32'd0);
    chk("rst_word_count", {23'd0, wc1},   32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", {31'd0, br1}, 32'd0);

    // Two full words, one byte per cycle.
    pulse_start1();
    chk("start_ready", {31'd0, br1}, 32'd1);
    send(8'h20, 0); send(8'h08, 0); send(8'h00, 0); send(8'h05, 0);
    send(8'h8C, 0); send(8'h09, 0); send(8'h00, 0); send(8'h04, 1);
    @(negedge clk);
    chk("full_we_cycle", {31'd0, we1}, 32'd1);
    chk("full_cpu_rst_in_write", {31'd0, cpu1}, 32'd1);
    @(negedge clk);
    chk("full_done",    {31'd0, done1}, 32'd1);
    chk("full_cpu_rst", {31'd0, cpu1},  32'd0);
    chk("full_wc",      {23'd0, wc1},   32'd2);
    chk("full_ovf",     {31'd0, ovf1},  32'd0);
    chk("full_nwr",     wa1.size(),     32'd2);
    if (wa1.size() == 2) begin
      chk("full_a0", wa1[0], 32'd0);
      chk("full_d0", wd1[0], 32'h2008_0005);
      chk("full_a1", wa1[1], 32'd1);
      chk("full_d1", wd1[1], 32'h8C09_0004);
    end
    // byte_valid in DONE is not accepted.
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = 8'h77;
    repeat (3) begin
      @(negedge clk);
      chk("done_no_ready", {31'd0, br1}, 32'd0);
    end
    byte_valid = 1'b0;
    chk("done_no_write", wa1.size(), 32'd2);
    wa1.delete(); wd1.delete();

    // Reload from DONE; partial word with valid gaps.
    pulse_start1();
    chk("reload_cpu_rst", {31'd0, cpu1},  32'd1);
    chk("reload_done",    {31'd0, done1}, 32'd0);
    chk("reload_wc",      {23'd0, wc1},   32'd0);
    send(8'hAA, 0);
    repeat (3) @(negedge clk);
    send(8'hBB, 1);
    repeat (2) @(negedge clk);
    chk("part_done", {31'd0, done1}, 32'd1);
    chk("part_wc",   {23'd0, wc1},   32'd1);
    chk("part_nwr",  wa1.size(),     32'd1);
    if (wa1.size() == 1) begin
      chk("part_a0", wa1[0], 32'd0);
      chk("part_d0", wd1[0], 32'hAABB_0000);
    end
    wa1.delete(); wd1.delete();

    // Reset in the middle of the second word.
    pulse_start1();
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
    send(8'h55, 0);
    pulse_start1();  // ignored in RECV
    chk("recv_start_wc",   {23'd0, wc1},   32'd1);
    chk("recv_start_addr", {24'd0, addr1}, 32'd1);
    send(8'h66, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_cpu_rst", {31'd0, cpu1},  32'd1);
    chk("mid_ready",   {31'd0, br1},   32'd0);
    chk("mid_addr",    {24'd0, addr1}, 32'd0);
    chk("mid_wc",      {23'd0, wc1},   32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_idle_ready", {31'd0, br1}, 32'd0);
    chk("mid_idle_cpu",   {31'd0, cpu1}, 32'd1);
    chk("mid_nwr", wa1.size(), 32'd1);
    if (wa1.size() == 1) chk("mid_d0", wd1[0], 32'h1122_3344);
    wa1.delete(); wd1.delete();
    pulse_start1();
    send(8'hDE, 0); send(8'hAD, 0); send(8'hBE, 0); send(8'hEF, 1);
    repeat (2) @(negedge clk);
    chk("after_rst_done", {31'd0, done1}, 32'd1);
    chk("after_rst_nwr",  wa1.size(), 32'd1);
    if (wa1.size() == 1) begin
      chk("after_rst_a0", wa1[0], 32'd0);
      chk("after_rst_d0", wd1[0], 32'hDEAD_BEEF);
    end
    wa1.delete(); wd1.delete();

    // Reload a 4-byte program.
    pulse_start1();
    chk("reload2_cpu_rst", {31'd0, cpu1},  32'd1);
    chk("reload2_done",    {31'd0, done1}, 32'd0);
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 1);
    repeat (2) @(negedge clk);
    chk("reload2_wc",  {23'd0, wc1}, 32'd1);
    chk("reload2_nwr", wa1.size(),   32'd1);
    if (wa1.size() == 1) begin
      chk("reload2_a0", wa1[0], 32'd0);
      chk("reload2_d0", wd1[0], 32'h0102_0304);
    end

    // Overflow on the 4-word instance.
    sel = 1'b1;
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int i = 0; i < 16; i++) send(i[7:0], 0);
    @(negedge clk);
    chk("ovf_we_cycle", {31'd0, we2},   32'd1);
    chk("ovf_we_addr",  {30'd0, addr2}, 32'd3);
    @(negedge clk);
    chk("ovf_flag",  {31'd0, ovf2},  32'd1);
    chk("ovf_done",  {31'd0, done2}, 32'd1);
    chk("ovf_cpu",   {31'd0, cpu2},  32'd0);
    chk("ovf_wc",    {29'd0, wc2},   32'd4);
    chk("ovf_addr",  {30'd0, addr2}, 32'd3);
    byte_valid = 1'b1;
    byte_data  = 8'h10;
    repeat (4) begin
      @(negedge clk);
      chk("ovf_no_ready", {31'd0, br2}, 32'd0);
    end
    byte_valid = 1'b0;
    chk("ovf_nwr", wa2.size(), 32'd4);
    if (wa2.size() == 4) begin
      chk("ovf_a0", wa2[0], 32'd0); chk("ovf_d0", wd2[0], 32'h0001_0203);
      chk("ovf_a1", wa2[1], 32'd1); chk("ovf_d1", wd2[1], 32'h0405_0607);
      chk("ovf_a2", wa2[2], 32'd2); chk("ovf_d2", wd2[2], 32'h0809_0A0B);
      chk("ovf_a3", wa2[3], 32'd3); chk("ovf_d3", wd2[3], 32'h0C0D_0E0F);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
